// File: rtl/data_mem_resp_if.sv
// Data-side bus between the RV32I core (master) and its memory responder (slave).
// The core drives address, data and sizes. The responder returns load data and the error interrupt.
interface data_mem_resp_if;
  logic        d_wr_en;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [1:0]  store_size;
  logic [1:0]  load_size;
  logic [31:0] dRdata;
  logic        err_irq;

  modport master (
    output d_wr_en, dAddr, dWdata, store_size, load_size,
    input  dRdata, err_irq
  );

  modport slave (
    input  d_wr_en, dAddr, dWdata, store_size, load_size,
    output dRdata, err_irq
  );
endinterface

// File: rtl/data_mem_resp.sv
// Data memory responder for the single-cycle RV32I core.
// It holds a byte-lane word RAM and an MMIO window with a cycle counter, a misalign counter and a W1C error status.
module data_mem_resp #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_resp_if.slave    bus
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    REG_CYCLE    = 2'b00,
    REG_MISALIGN = 2'b01,
    REG_ERR      = 2'b10,
    REG_NONE     = 2'b11
  } mmio_reg_e;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_cycle_cnt;
  logic [15:0] r_misalign_cnt;
  logic [1:0]  r_err_status;
  logic        r_err_irq;

  logic            w_is_ram;
  logic            w_is_mmio;
  mmio_reg_e       w_reg_sel;
  size_e           w_ld_size;
  size_e           w_st_size;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_ram_word;
  logic [31:0]     w_ram_shifted;
  logic            w_load_ok;
  logic            w_store_ok;
  logic            w_mmio_word;
  logic            w_ram_we;
  logic            w_mmio_we;
  logic            w_err_misalign;
  logic            w_err_unmapped;
  logic [1:0]      w_err_clr;
  logic [1:0]      w_err_next;
  logic [3:0]      w_be;
  logic [31:0]     w_wlanes;
  logic [31:0]     w_rdata;

  // RAM takes priority, so an MMIO base placed inside RAM cannot alias a RAM word.
  assign w_is_ram   = (bus.dAddr < RAM_BYTES);
  assign w_is_mmio  = !w_is_ram && (bus.dAddr[31:4] == MMIO_BASE[31:4]) && (bus.dAddr[3:2] != 2'b11);
  assign w_reg_sel  = mmio_reg_e'(bus.dAddr[3:2]);
  assign w_ld_size  = size_e'(bus.load_size);
  assign w_st_size  = size_e'(bus.store_size);
  assign w_idx      = bus.dAddr[AW+1:2];
  assign w_ram_word = r_mem[w_idx];

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_load_ok  = 1'b0;
    w_store_ok = 1'b0;
    case (w_ld_size)
      SZ_BYTE: w_load_ok = 1'b1;
      SZ_HALF: w_load_ok = !bus.dAddr[0];
      default: w_load_ok = (bus.dAddr[1:0] == 2'b00);
    endcase
    case (w_st_size)
      SZ_BYTE: w_store_ok = 1'b1;
      SZ_HALF: w_store_ok = !bus.dAddr[0];
      SZ_WORD: w_store_ok = (bus.dAddr[1:0] == 2'b00);
      default: w_store_ok = 1'b0;
    endcase
  end

  assign w_ram_shifted = w_ram_word >> {bus.dAddr[1:0], 3'b000};

  always_comb begin
    w_rdata = '0;
    if (w_load_ok && w_is_ram) begin
      case (w_ld_size)
        SZ_BYTE: w_rdata = {24'b0, w_ram_shifted[7:0]};
        SZ_HALF: w_rdata = {16'b0, w_ram_shifted[15:0]};
        default: w_rdata = w_ram_word;
      endcase
    end else if (w_load_ok && w_is_mmio) begin
      case (w_reg_sel)
        REG_CYCLE:    w_rdata = r_cycle_cnt;
        REG_MISALIGN: w_rdata = {16'b0, r_misalign_cnt};
        REG_ERR:      w_rdata = {30'b0, r_err_status};
        default:      w_rdata = '0;
      endcase
    end
  end

  // MMIO accepts only word stores. Narrower MMIO stores count as misaligned.
  assign w_mmio_word    = w_is_mmio && (w_st_size == SZ_WORD);
  assign w_err_misalign = bus.d_wr_en && (!w_store_ok || (w_is_mmio && !w_mmio_word));
  assign w_err_unmapped = bus.d_wr_en && w_store_ok && !w_is_ram && !w_is_mmio;
  assign w_ram_we       = bus.d_wr_en && w_store_ok && w_is_ram;
  assign w_mmio_we      = bus.d_wr_en && w_store_ok && w_mmio_word;

  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = bus.dWdata;
    case (w_st_size)
      SZ_BYTE: begin
        w_be     = 4'b0001 << bus.dAddr[1:0];
        w_wlanes = {4{bus.dWdata[7:0]}};
      end
      SZ_HALF: begin
        w_be     = bus.dAddr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{bus.dWdata[15:0]}};
      end
      SZ_WORD: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // NOTE: RAM contents are deliberately not reset. Only the write is gated by rst, so a store during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  // A new error in the same cycle as a W1C write keeps its bit set.
  assign w_err_clr  = (w_mmio_we && (w_reg_sel == REG_ERR)) ? bus.dWdata[1:0] : 2'b00;
  assign w_err_next = (r_err_status & ~w_err_clr) | {w_err_unmapped, w_err_misalign};

  // NOTE: sequential state uses non-blocking assignments, so all registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cycle_cnt    <= '0;
      r_misalign_cnt <= '0;
      r_err_status   <= '0;
      r_err_irq      <= 1'b0;
    end else begin
      if (w_mmio_we && (w_reg_sel == REG_CYCLE)) r_cycle_cnt <= bus.dWdata;
      else                                       r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_err_misalign && (r_misalign_cnt != 16'hFFFF)) r_misalign_cnt <= r_misalign_cnt + 16'd1;
      r_err_status <= w_err_next;
      r_err_irq    <= |w_err_next;
    end
  end

  assign bus.dRdata  = w_rdata;
  assign bus.err_irq = r_err_irq;

endmodule
